// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, latches the fetched word into IF/ID
// with a valid/ready handshake, pre-decodes the opcode and halts on illegal words.
module fetch_stage #(
  parameter int AW       = 7,
  parameter int RESET_PC = 0,
  parameter int CW       = 16,
  parameter bit HALT_ILL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_data,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_npc,
  output logic [2:0]    id_op,
  output logic          halted,
  output logic [CW-1:0] fetch_cnt
);

  // state  | meaning
  // S_RUN  | fetching normally
  // S_HALT | illegal opcode latched; fetch frozen until redirect or reset
  typedef enum logic {S_RUN, S_HALT} state_t;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_LW    = 3'd1;
  localparam logic [2:0] OP_SW    = 3'd2;
  localparam logic [2:0] OP_BEQ   = 3'd3;
  localparam logic [2:0] OP_ILL   = 3'd7;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [AW-1:0]   r_id_pc;
  logic [AW-1:0]   r_id_npc;
  logic [2:0]      r_id_op;
  logic [CW-1:0]   r_fetch_cnt;
  logic [2:0]      w_op;
  logic            w_free;
  logic            w_advance;
  logic [AW-1:0]   w_pc_inc;

  always_comb begin
    w_op = OP_ILL;
    case (mem_data[31:26])
      6'b000000: w_op = OP_RTYPE;
      6'b100011: w_op = OP_LW;
      6'b101011: w_op = OP_SW;
      6'b000100: w_op = OP_BEQ;
      default:   w_op = OP_ILL;
    endcase
  end

  assign w_free    = !r_id_valid || id_ready;
  assign w_advance = w_free && !stall && (r_state == S_RUN);
  assign w_pc_inc  = r_pc + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    if (br_taken)
      w_state_nxt = S_RUN;
    else if (w_advance && (w_op == OP_ILL) && HALT_ILL)
      w_state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= AW'(RESET_PC);
      r_id_valid  <= 1'b0;
      r_id_instr  <= '0;
      r_id_pc     <= '0;
      r_id_npc    <= '0;
      r_id_op     <= '0;
      r_fetch_cnt <= '0;
    end else if (br_taken) begin
      // flush wins over stall and over a pending handshake
      r_pc       <= br_target;
      r_id_valid <= 1'b0;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_advance) begin
      r_id_instr  <= mem_data;
      r_id_pc     <= r_pc;
      r_id_npc    <= w_pc_inc;
      r_id_op     <= w_op;
      r_id_valid  <= 1'b1;
      r_pc        <= w_pc_inc;
      r_fetch_cnt <= r_fetch_cnt + CW'(1);
    end else if (r_id_valid && id_ready) begin
      // consumed while halted: nothing new to present
      r_id_valid <= 1'b0;
    end
  end

  assign mem_addr  = r_pc;
  assign id_valid  = r_id_valid;
  assign id_instr  = r_id_instr;
  assign id_pc     = r_id_pc;
  assign id_npc    = r_id_npc;
  assign id_op     = r_id_op;
  assign halted    = (r_state == S_HALT);
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected IF/ID words popped on
// each accepted handshake, plus direct checks of PC, counter and halt state.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  pc;
    logic [6:0]  npc;
    logic [2:0]  op;
  } exp_t;

  logic        clk;
  logic        rst, stall, br_taken, id_ready;
  logic [6:0]  br_target;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic        id_valid, halted;
  logic [31:0] id_instr;
  logic [6:0]  id_pc, id_npc;
  logic [2:0]  id_op;
  logic [15:0] fetch_cnt;

  logic        rst2, stall2, br2, ready2;
  logic [6:0]  tgt2;
  logic [6:0]  mem_addr2;
  logic [31:0] mem_data2;
  logic        id_valid2, halted2;
  logic [31:0] id_instr2;
  logic [6:0]  id_pc2, id_npc2;
  logic [2:0]  id_op2;
  logic [15:0] fetch_cnt2;

  logic [31:0] mem_a [0:127];
  logic [31:0] mem_b [0:127];
  exp_t        sb[$];
  int          n_err;
  int          n_checks;

  assign mem_data  = mem_a[mem_addr];
  assign mem_data2 = mem_b[mem_addr2];

  fetch_stage dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_npc(id_npc), .id_op(id_op), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  fetch_stage #(.RESET_PC(127)) dut2 (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .stall(stall2), .br_taken(br2), .br_target(tgt2),
    .id_ready(ready2), .id_valid(id_valid2), .id_instr(id_instr2),
    .id_pc(id_pc2), .id_npc(id_npc2), .id_op(id_op2), .halted(halted2),
    .fetch_cnt(fetch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL sb_underflow: observed instr %0h with empty scoreboard", id_instr);
    end else begin
      e = sb.pop_front();
      chk("sb_valid", {31'd0, id_valid}, 32'd1);
      chk("sb_instr", id_instr, e.instr);
      chk("sb_pc", {25'd0, id_pc}, {25'd0, e.pc});
      chk("sb_npc", {25'd0, id_npc}, {25'd0, e.npc});
      chk("sb_op", {29'd0, id_op}, {29'd0, e.op});
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [6:0] pc,
                      input logic [6:0] npc, input logic [2:0] op);
    exp_t e;
    e.instr = instr; e.pc = pc; e.npc = npc; e.op = op;
    sb.push_back(e);
  endtask

  // One clock: if decode accepts the presented word this edge, score it first.
  task automatic cycle();
    if (id_valid && id_ready && !stall) sb_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'h002300AA;
    mem_a[1] = 32'h10654321;
    mem_a[2] = 32'h00100022;
    mem_a[3] = 32'h8C123456;
    mem_a[4] = 32'hFC000000;
    mem_a[5] = 32'hAD654321;
    mem_b[127] = 32'h8C000001;
    mem_b[0]   = 32'h00000005;

    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 7'd0; id_ready = 1'b0;
    rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; tgt2 = 7'd0; ready2 = 1'b1;
    cycle();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", {25'd0, id_pc}, 32'd0);
    chk("rst_npc", {25'd0, id_npc}, 32'd0);
    chk("rst_op", {29'd0, id_op}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    chk("rst_addr", {25'd0, mem_addr}, 32'd0);

    // straight-line fetch of three words
    rst = 1'b0; id_ready = 1'b1;
    push(32'h002300AA, 7'd0, 7'd1, 3'd0);
    push(32'h10654321, 7'd1, 7'd2, 3'd3);
    push(32'h00100022, 7'd2, 7'd3, 3'd0);
    cycle(); cycle(); cycle();
    chk("seq_cnt", {16'd0, fetch_cnt}, 32'd3);

    // decode back-pressure: word and PC must hold
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_instr", id_instr, 32'h00100022);
      chk("bp_addr", {25'd0, mem_addr}, 32'd3);
      chk("bp_cnt", {16'd0, fetch_cnt}, 32'd3);
    end
    id_ready = 1'b1;
    push(32'h8C123456, 7'd3, 7'd4, 3'd1);
    cycle();
    push(32'hFC000000, 7'd4, 7'd5, 3'd7);
    cycle();
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_addr", {25'd0, mem_addr}, 32'd5);
    chk("ill_cnt", {16'd0, fetch_cnt}, 32'd5);
    cycle();
    chk("halt_valid", {31'd0, id_valid}, 32'd0);
    chk("halt_addr", {25'd0, mem_addr}, 32'd5);
    cycle();
    chk("halt_cnt", {16'd0, fetch_cnt}, 32'd5);
    chk("halt_still", {31'd0, halted}, 32'd1);

    // redirect out of halt
    br_taken = 1'b1; br_target = 7'd0;
    cycle();
    chk("br_halted", {31'd0, halted}, 32'd0);
    chk("br_addr", {25'd0, mem_addr}, 32'd0);
    chk("br_cnt", {16'd0, fetch_cnt}, 32'd5);
    br_taken = 1'b0;
    push(32'h002300AA, 7'd0, 7'd1, 3'd0);
    cycle();
    sb_check();

    // branch and stall on the same edge: flush wins
    stall = 1'b1; br_taken = 1'b1; br_target = 7'd5;
    cycle();
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_addr", {25'd0, mem_addr}, 32'd5);
    chk("flush_cnt", {16'd0, fetch_cnt}, 32'd6);
    stall = 1'b0; br_taken = 1'b0;
    push(32'hAD654321, 7'd5, 7'd6, 3'd2);
    cycle();
    id_ready = 1'b0;
    cycle();
    chk("tgt_cnt", {16'd0, fetch_cnt}, 32'd7);
    chk("tgt_addr", {25'd0, mem_addr}, 32'd6);
    sb_check();
    chk("sb_empty", sb.size(), 32'd0);

    // second instance: reset PC at top of memory, wrap of pc/npc
    rst2 = 1'b0;
    cycle();
    chk("wrap_pc", {25'd0, id_pc2}, 32'd127);
    chk("wrap_npc", {25'd0, id_npc2}, 32'd0);
    chk("wrap_op", {29'd0, id_op2}, 32'd1);
    chk("wrap_addr", {25'd0, mem_addr2}, 32'd0);
    cycle();
    chk("wrap2_instr", id_instr2, 32'h00000005);
    chk("wrap2_pc", {25'd0, id_pc2}, 32'd0);
    chk("wrap2_npc", {25'd0, id_npc2}, 32'd1);
    chk("wrap2_cnt", {16'd0, fetch_cnt2}, 32'd2);
    rst2 = 1'b1;
    cycle();
    chk("rst2_valid", {31'd0, id_valid2}, 32'd0);
    chk("rst2_addr", {25'd0, mem_addr2}, 32'd127);
    chk("rst2_cnt", {16'd0, fetch_cnt2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
